// File: rtl/otter_fetch_queue_if.sv
// Purpose: bundles the redirect, instruction-memory and decode handshakes of the fetch queue.
// Latency: none; wiring only.
// Backpressure: IMEM_GNT stalls requests, DE_READY stalls the decode-side head entry.
interface otter_fetch_queue_if;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DE_READY;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        IF_VALID;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC;
    logic [31:0] IF_NEXT_PC;

    // fetch unit side
    modport master (
        input  REDIRECT, REDIRECT_PC, DE_READY, IMEM_GNT, IMEM_RVALID, IMEM_RDATA,
        output IMEM_REQ, IMEM_ADDR, IF_VALID, IF_IR, IF_PC, IF_NEXT_PC
    );

    // memory / decode / execute side
    modport slave (
        output REDIRECT, REDIRECT_PC, DE_READY, IMEM_GNT, IMEM_RVALID, IMEM_RDATA,
        input  IMEM_REQ, IMEM_ADDR, IF_VALID, IF_IR, IF_PC, IF_NEXT_PC
    );
endinterface

// File: rtl/otter_fetch_queue.sv
// Purpose: OTTER fetch front end; owns fetch PC, issues in-order IMEM requests, queues returned words for decode.
// Latency: RDATA is registered into the queue; IF_VALID rises the cycle after RVALID (REQ cycle 0 -> IF_VALID cycle 2 at latency 1).
// Backpressure: IMEM_REQ drops once reserved + stale responses reach DEPTH; head entry holds while DE_READY is low.
module otter_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RESET,
    otter_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [CW-1:0]   head_q;
    logic [CW-1:0]   tail_q;
    logic [CW-1:0]   fill_q;      // oldest reserved-but-unfilled entry
    logic [CW-1:0]   drop_cnt;    // responses still owed for flushed requests
    logic [31:0]     fetch_pc;
    logic [31:0]     pc_q [DEPTH];
    logic [31:0]     ir_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] filled_nxt;

    logic [AW-1:0]   head_idx;
    logic [AW-1:0]   tail_idx;
    logic [AW-1:0]   fill_idx;
    logic [CW-1:0]   reserved;
    logic [CW-1:0]   unfilled;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   drop_redir;
    logic            req;
    logic            gnt;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            if_vld;
    logic            pop;
    logic            unused_bits;

    assign head_idx    = head_q[AW-1:0];
    assign tail_idx    = tail_q[AW-1:0];
    assign fill_idx    = fill_q[AW-1:0];
    assign reserved    = tail_q - head_q;
    assign unfilled    = tail_q - fill_q;
    assign credit_used = {1'b0, reserved} + {1'b0, drop_cnt};

    // Stale responses occupy credit too, so memory never holds more than DEPTH requests.
    assign req      = !RESET && !bus.REDIRECT && (credit_used < DEPTH_W);
    assign gnt      = req && bus.IMEM_GNT;
    assign rsp_drop = bus.IMEM_RVALID && (drop_cnt != '0);
    // A response with nothing outstanding is ignored rather than corrupting the queue.
    assign rsp_fill = bus.IMEM_RVALID && (drop_cnt == '0) && (unfilled != '0);
    assign if_vld   = filled_q[head_idx] && !RESET;
    assign pop      = if_vld && bus.DE_READY && !bus.REDIRECT;

    // On redirect every unfilled entry becomes a stale response; one arriving this cycle is already accounted for.
    assign drop_redir = drop_cnt + unfilled - CW'(rsp_drop | rsp_fill);

    assign bus.IMEM_REQ   = req;
    assign bus.IMEM_ADDR  = fetch_pc;
    assign bus.IF_VALID   = if_vld;
    assign bus.IF_IR      = ir_q[head_idx];
    assign bus.IF_PC      = pc_q[head_idx];
    assign bus.IF_NEXT_PC = pc_q[head_idx] + 32'd4;

    // Low address bits of the redirect target are discarded by word alignment.
    assign unused_bits = ^bus.REDIRECT_PC[1:0];

    // Per-entry filled flags: set on accepted response, cleared on pop.
    always_comb begin
        filled_nxt = filled_q;
        if (rsp_fill) filled_nxt[fill_idx] = 1'b1;
        if (pop)      filled_nxt[head_idx] = 1'b0;
    end

    // Control state: reset, then redirect flush, then normal grant/fill/pop updates.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            drop_cnt <= '0;
            filled_q <= '0;
        end else if (bus.REDIRECT) begin
            fetch_pc <= {bus.REDIRECT_PC[31:2], 2'b00};
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            drop_cnt <= drop_redir;
            filled_q <= '0;
        end else begin
            drop_cnt <= drop_cnt - CW'(rsp_drop);
            filled_q <= filled_nxt;
            if (gnt) begin
                tail_q   <= tail_q + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_fill) fill_q <= fill_q + 1'b1;
            if (pop)      head_q <= head_q + 1'b1;
        end
    end

    // Queue payload: PC captured at grant, instruction word captured at response.
    always_ff @(posedge CLK) begin
        if (gnt)                                   pc_q[tail_idx] <= fetch_pc;
        if (rsp_fill && !RESET && !bus.REDIRECT)   ir_q[fill_idx] <= bus.IMEM_RDATA;
    end
endmodule

// File: tb/tb_otter_fetch_queue.sv
// Purpose: self-checking bench for otter_fetch_queue with an in-order variable-latency memory model.
// Latency: one bench step per clock; inputs driven and outputs sampled at the falling edge.
// Backpressure: DE_READY and IMEM_GNT are driven per step by the stimulus.
module tb_otter_fetch_queue;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    otter_fetch_queue_if bus();

    otter_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;
    int          lat   = 1;
    int          last_due = 0;
    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = RST_PC;
    logic        popped;
    logic [31:0] popped_pc;
    logic [31:0] popped_ir;
    logic        seen_valid;

    function automatic logic [31:0] insn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // One clock of stimulus plus scoreboard bookkeeping for that clock.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                        input logic rdy, input logic gnt);
        mreq_t       m;
        int          due;
        logic [31:0] e;
        @(negedge CLK);
        cyc_n++;
        RESET           = rst;
        bus.REDIRECT    = redir;
        bus.REDIRECT_PC = rpc;
        bus.DE_READY    = rdy;
        bus.IMEM_GNT    = gnt;
        bus.IMEM_RVALID = 1'b0;
        bus.IMEM_RDATA  = $urandom;
        if (rst) begin
            mq.delete();
            last_due = 0;
        end else if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            m = mq.pop_front();
            bus.IMEM_RVALID = 1'b1;
            bus.IMEM_RDATA  = insn(m.addr);
        end
        #1;
        popped     = 1'b0;
        seen_valid = bus.IF_VALID;
        if (rst) begin
            check_eq("req_in_reset", 32'(bus.IMEM_REQ), 32'd0);
            check_eq("vld_in_reset", 32'(bus.IF_VALID), 32'd0);
            exp_q.delete();
            exp_addr = RST_PC;
        end else begin
            if (redir) check_eq("req_in_redirect", 32'(bus.IMEM_REQ), 32'd0);
            if (bus.IMEM_REQ && gnt) begin
                check_eq("imem_addr", bus.IMEM_ADDR, exp_addr);
                due = cyc_n + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{bus.IMEM_ADDR, due});
                exp_q.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            if (bus.IF_VALID && rdy && !redir) begin
                popped    = 1'b1;
                popped_pc = bus.IF_PC;
                popped_ir = bus.IF_IR;
                if (exp_q.size() == 0) begin
                    check_eq("pop_unexpected", 32'(bus.IF_VALID), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("if_pc", bus.IF_PC, e);
                    check_eq("if_ir", bus.IF_IR, insn(e));
                    check_eq("if_next_pc", bus.IF_NEXT_PC, e + 32'd4);
                end
            end
            if (redir) begin
                exp_q.delete();
                exp_addr = {rpc[31:2], 2'b00};
            end
        end
    endtask

    // Runs until the next pop or the budget expires; a miss counts as a failure.
    task automatic run_to_pop(input string tag, input logic [31:0] want_pc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            got = popped;
        end
        check_eq({tag, "_popped"}, 32'(got), 32'd1);
        if (got) begin
            check_eq({tag, "_pc"}, popped_pc, want_pc);
            check_eq({tag, "_ir"}, popped_ir, insn(want_pc));
        end
    endtask

    initial begin
        int   first;
        logic full;
        logic rdy, gnt, rd;

        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

        // Streaming from reset at latency 1: first valid two cycles after release, back-to-back pops.
        lat   = 1;
        first = -1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            if (seen_valid && first < 0) first = i;
            if (i >= 2) begin
                check_eq("t1_stream_vld", 32'(seen_valid), 32'd1);
                check_eq("t1_pc", popped_pc, 32'((i - 2) * 4));
            end
        end
        check_eq("t1_first_valid_cycle", 32'(first), 32'd2);

        // Decode stall on head 0x10: head holds, requests stop at DEPTH reservations.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            check_eq("t2_hold_vld", 32'(bus.IF_VALID), 32'd1);
            check_eq("t2_hold_pc", bus.IF_PC, 32'h10);
            check_eq("t2_hold_ir", bus.IF_IR, insn(32'h10));
        end
        check_eq("t2_req_full", 32'(bus.IMEM_REQ), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            check_eq("t2_release_pop", 32'(popped), 32'd1);
            check_eq("t2_release_pc", popped_pc, 32'h10 + 32'(4 * i));
        end

        // Latency 3, two requests in flight, then redirect: both old responses must be dropped.
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        lat = 3;
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("t3_req_after_redir", 32'(bus.IMEM_REQ), 32'd1);
        run_to_pop("t3", 32'h200);

        // Unaligned redirect target is word-aligned.
        step(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t4_addr", bus.IMEM_ADDR, 32'h200);
        run_to_pop("t4", 32'h200);

        // Redirect while a live response returns and decode is ready.
        lat = 1;
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
        check_eq("t5_vld_at_redir", 32'(seen_valid), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        check_eq("t5_vld_after", 32'(seen_valid), 32'd0);
        run_to_pop("t5", 32'h300);

        // Fill the queue, then a one-cycle reset must discard everything.
        full = 1'b0;
        for (int i = 0; i < 20 && !full; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            full = !bus.IMEM_REQ;
        end
        check_eq("t6_full_reached", 32'(full), 32'd1);
        check_eq("t6_full_vld", 32'(bus.IF_VALID), 32'd1);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t6_vld", 32'(seen_valid), 32'd0);
        check_eq("t6_addr", bus.IMEM_ADDR, RST_PC);
        check_eq("t6_req", 32'(bus.IMEM_REQ), 32'd1);
        run_to_pop("t6", RST_PC);

        // Random traffic: variable latency, sporadic grants, stalls and redirects.
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            gnt = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 29) == 0);
            lat = $urandom_range(1, 4);
            step(1'b0, rd, $urandom, rdy, gnt);
        end
        repeat (30) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("drain_vld", 32'(bus.IF_VALID), 32'd0);
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=%0d", cyc_n, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/otter_fetch_queue.md
Name: otter_fetch_queue

Overview:
Instruction fetch front end for the pipelined OTTER. Owns the fetch PC and issues in-order requests to an instruction memory that may have variable latency. Holds returned instruction words in a small prefetch queue and presents them, tagged with their PC, to the decode stage through a valid/ready handshake. A redirect from execute, caused by a taken branch, JAL or JALR, flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, queue slots and maximum outstanding memory requests (power of 2, at least 2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
REDIRECT  in  1  execute-stage PC redirect strobe
REDIRECT_PC  in  32  redirect target
DE_READY  in  1  decode accepts the head instruction this cycle
IMEM_REQ  out  1  fetch request valid
IMEM_ADDR  out  32  fetch address, word aligned
IMEM_GNT  in  1  memory accepts the request this cycle
IMEM_RVALID  in  1  read data valid; responses return in request order
IMEM_RDATA  in  32  instruction word
IF_VALID  out  1  head entry valid
IF_IR  out  32  head instruction
IF_PC  out  32  head PC
IF_NEXT_PC  out  32  IF_PC + 4

Behaviour:
Clock and reset:
- One clock. RESET is synchronous, active-high.

State:
- fetch_pc.
- Circular queue of DEPTH entries, each holding {pc, ir, filled}, with head/tail pointers.
- reserved: count of entries allocated, filled or not.
- drop_cnt: count of stale responses still outstanding.

Reset:
- fetch_pc = RESET_PC; reserved = 0; drop_cnt = 0; pointers = 0; all filled = 0.
- Outputs: IF_VALID = 0; IMEM_REQ = 0 during any cycle RESET is high.
- RESET mid-operation discards everything. The instruction memory is reset by the same RESET, so no response arrives afterwards.

Request side:
- IMEM_REQ = !RESET && !REDIRECT && (reserved + drop_cnt < DEPTH).
- IMEM_ADDR = fetch_pc.
- Grant (IMEM_REQ && IMEM_GNT): allocate the tail entry with pc = fetch_pc and filled = 0; tail++; reserved++; fetch_pc += 4 (32-bit wrap).
- IMEM_ADDR is held stable while IMEM_REQ is high and not granted.

Response side:
- On IMEM_RVALID with drop_cnt > 0: decrement drop_cnt and discard the data.
- Otherwise: write IMEM_RDATA into the oldest unfilled entry and set filled.
- IMEM_RVALID with no outstanding request is illegal; ignore it and do not underflow.

Decode side:
- IF_VALID = head entry filled. IF_IR, IF_PC and IF_NEXT_PC come from the head entry (registered state).
- Pop on IF_VALID && DE_READY: clear filled, head++, reserved--.
- Outputs stay stable while IF_VALID && !DE_READY.
- Same-cycle pop and grant are both performed; reserved is unchanged.

Latency and throughput:
- RDATA is registered into the queue; no bypass.
- First IF_VALID appears the cycle after the first RVALID. With a memory that grants immediately and returns one cycle later: REQ in cycle 0, IF_VALID in cycle 2.
- Sustains one instruction per cycle when latency < DEPTH - 1.

Redirect (highest priority after RESET):
- fetch_pc = {REDIRECT_PC[31:2], 2'b00}.
- All entries invalidated; head = tail = 0; reserved = 0.
- drop_cnt += number of outstanding unreturned requests. This is the count of unfilled reserved entries, minus 1 if a non-dropped RVALID arrives in the same cycle (that response is also discarded).
- A pop requested in the redirect cycle is ignored. IF_VALID is 0 the next cycle.
- Redirect in consecutive cycles: the last target wins; drop_cnt accumulates correctly.

Full condition:
- IMEM_REQ drops once reserved + drop_cnt = DEPTH. It reasserts the cycle after a pop or a dropped response frees credit.

Test Plan:
1. RESET_PC = 0x0, memory grants immediately with latency 1, DE_READY = 1 -> IF_PC = 0x0, 0x4, 0x8, 0xC on consecutive cycles; first IF_VALID is 2 cycles after RESET falls; IF_NEXT_PC = 0x4, 0x8, 0xC, 0x10.
2. DE_READY low for 6 cycles while head is PC 0x10 -> IMEM_REQ low after 4 reservations; IF_PC/IF_IR hold 0x10 steady. On release, PCs 0x10, 0x14, 0x18, 0x1C, 0x20 appear with no loss or duplicate.
3. Memory latency 3 with 2 requests outstanding; REDIRECT with REDIRECT_PC = 0x200 -> both old responses dropped (drop_cnt 2 -> 0); next IF_PC = 0x200 with the correct IR.
4. REDIRECT_PC = 0x203 -> IMEM_ADDR = 0x200.
5. REDIRECT in the same cycle as a non-stale IMEM_RVALID and DE_READY = 1 -> the returning word is discarded, no pop occurs, IF_VALID = 0 next cycle, first post-redirect IF_PC equals the target.
6. Queue full (4 entries) and RESET pulsed for 1 cycle -> next cycle IF_VALID = 0, IMEM_ADDR = RESET_PC, IMEM_REQ = 1, drop_cnt = 0.
